// File: rtl/bit_index_encoder8x3.sv
// rtl/bit_index_encoder8x3.sv - sequential 8-to-3 encoder emitting one set-bit index per beat
module bit_index_encoder8x3 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_vec,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_code,
  output logic       out_none,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] out_code_q, out_code_d;
  logic       out_none_q, out_none_d;
  logic       out_last_q, out_last_d;
  logic       out_valid_q, out_valid_d;

  // Index of the bit to emit next; 0 for an empty mask.
  function automatic logic [2:0] prio_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (m[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic one_hot(input logic [7:0] m);
    return (m != 8'h00) && ((m & (m - 8'd1)) == 8'h00);
  endfunction

  // Next state and next beat; beat fields are computed from the next mask so they can be registered.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    out_none_d = out_none_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = EMIT;
          mask_d     = in_vec;
          out_none_d = (in_vec == 8'h00);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = IDLE;
            mask_d     = 8'h00;
            out_none_d = 1'b0;
          end else begin
            mask_d = mask_q & ~(8'b1 << out_code_q);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        mask_d     = 8'h00;
        out_none_d = 1'b0;
      end
    endcase
    out_valid_d = (state_d == EMIT);
    out_code_d  = out_valid_d ? prio_idx(mask_d) : 3'd0;
    out_last_d  = out_valid_d && (out_none_d || one_hot(mask_d));
  end

  // State, pending mask and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= 8'h00;
      out_code_q  <= 3'd0;
      out_none_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      out_code_q  <= out_code_d;
      out_none_q  <= out_none_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_code  = out_code_q;
  assign out_none  = out_none_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bit_index_encoder8x3.sv
// tb/tb_bit_index_encoder8x3.sv - directed vector bench for both index orders
module tb_bit_index_encoder8x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       out_ready;

  logic       l_in_ready, l_none, l_last, l_valid;
  logic [2:0] l_code;
  logic       m_in_ready, m_none, m_last, m_valid;
  logic [2:0] m_code;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bit_index_encoder8x3 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(l_in_ready),
    .out_code(l_code), .out_none(l_none), .out_last(l_last), .out_valid(l_valid),
    .out_ready(out_ready)
  );

  bit_index_encoder8x3 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(m_in_ready),
    .out_code(m_code), .out_none(m_none), .out_last(m_last), .out_valid(m_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0]      vec;
    int              n;
    logic [7:0][2:0] lsb;
    logic [7:0][2:0] msb;
    logic            none;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " lsb out_valid"}, int'(l_valid), 0);
    chk({tag, " msb out_valid"}, int'(m_valid), 0);
    chk({tag, " lsb in_ready"}, int'(l_in_ready), 1);
    chk({tag, " msb in_ready"}, int'(m_in_ready), 1);
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] lc, input logic [2:0] mc,
                          input logic last, input logic none);
    chk({tag, " lsb valid"}, int'(l_valid), 1);
    chk({tag, " msb valid"}, int'(m_valid), 1);
    chk({tag, " lsb code"}, int'(l_code), int'(lc));
    chk({tag, " msb code"}, int'(m_code), int'(mc));
    chk({tag, " lsb last"}, int'(l_last), int'(last));
    chk({tag, " msb last"}, int'(m_last), int'(last));
    chk({tag, " lsb none"}, int'(l_none), int'(none));
    chk({tag, " msb none"}, int'(m_none), int'(none));
    chk({tag, " lsb in_ready"}, int'(l_in_ready), 0);
    chk({tag, " msb in_ready"}, int'(m_in_ready), 0);
  endtask

  // Called at a negedge with both instances idle; returns at a negedge after the vector drains.
  task automatic run_vec(input vec_t v);
    string tag;
    chk_idle($sformatf("pre %02h", v.vec));
    in_vec    = v.vec;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 8'h5A;
    for (int k = 0; k < v.n; k++) begin
      tag = $sformatf("vec %02h beat %0d", v.vec, k);
      chk_beat(tag, v.lsb[k], v.msb[k], (k == v.n - 1), v.none);
      @(negedge clk);
    end
    chk_idle($sformatf("post %02h", v.vec));
  endtask

  initial begin
    tbl[0] = '{8'h04, 1, {21'd0, 3'd2}, {21'd0, 3'd2}, 1'b0};
    tbl[1] = '{8'hA3, 4, {12'd0, 3'd7, 3'd5, 3'd1, 3'd0}, {12'd0, 3'd0, 3'd1, 3'd5, 3'd7}, 1'b0};
    tbl[2] = '{8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                         {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 1'b0};
    tbl[3] = '{8'h00, 1, 24'd0, 24'd0, 1'b1};
    tbl[4] = '{8'h81, 2, {18'd0, 3'd7, 3'd0}, {18'd0, 3'd0, 3'd7}, 1'b0};
    tbl[5] = '{8'h18, 2, {18'd0, 3'd4, 3'd3}, {18'd0, 3'd3, 3'd4}, 1'b0};

    rst_n     = 1'b1;
    in_vec    = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #7 rst_n = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset lsb code", int'(l_code), 0);
    chk("reset lsb last", int'(l_last), 0);
    chk("reset lsb none", int'(l_none), 0);
    chk("reset msb last", int'(m_last), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Backpressure: beat holds, in_vec changes are ignored.
    in_vec    = 8'h12;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_beat($sformatf("stall %0d", c), 3'd1, 3'd4, 1'b0, 1'b0);
      in_vec = 8'(c * 37 + 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk_beat("unstall 0", 3'd1, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("unstall 1", 3'd4, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle("after stall");

    // Reset in the middle of a vector.
    in_vec   = 8'hF0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("f0 beat 0", 3'd4, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("f0 beat 1", 3'd5, 3'd6, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("mid reset");
    chk("mid reset lsb code", int'(l_code), 0);
    chk("mid reset msb last", int'(m_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle($sformatf("post reset %0d", c));
    end
    run_vec('{8'h01, 1, 24'd0, 24'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bit_index_encoder8x3.md
# bit_index_encoder8x3

Sequential 8-to-3 encoder: the inverse of the 3x8 one-hot decoder in the combinational decoder library. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per output handshake, in priority order. A last-beat flag marks the end of each vector. It sits between request-collection logic and any consumer that drives a 3x8 decoder or indexes a table.

## Interface
- LSB_FIRST, 1, index order: 1 = emit lowest set bit first; 0 = highest set bit first.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_vec  input  8  request vector; sampled on an input handshake.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- out_code  output  3  index (0..7) of the current set bit.
- out_none  output  1  the current beat came from an all-zero vector.
- out_last  output  1  the current beat is the final one for the vector.
- out_valid  output  1  out_code, out_none and out_last are valid.
- out_ready  input  1  consumer accepts the current beat.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Input handshake (in_valid & in_ready) in IDLE:
  - Captures in_vec into the internal 8-bit pending mask.
  - Goes to EMIT.
- Beat contents in EMIT:
  - out_code = index of the priority bit of the pending mask: lowest set bit if LSB_FIRST=1, highest set bit if LSB_FIRST=0.
  - out_last = 1 when the pending mask has exactly one bit set.
- All-zero vector:
  - Exactly one beat: out_code=0, out_none=1, out_last=1.
  - out_none=0 on every beat from a non-zero vector.
- Output handshake (out_valid & out_ready) in EMIT:
  - Clears the emitted bit from the pending mask.
  - If out_last=1, goes to IDLE.
- Stall: while out_valid=1 and out_ready=0, all outputs and the pending mask hold.
- Number of beats per vector = popcount(in_vec), or 1 if in_vec=0.
- in_vec changes while in EMIT are ignored; only the captured mask is used.
- Reset mid-operation:
  - Pending mask is discarded and set to 0.
  - State returns to IDLE.
  - No further beats from the interrupted vector.

## Timing
- Reset values:
  - out_valid=0, out_code=0, out_none=0, out_last=0.
  - in_ready=1, pending mask=0, state=IDLE.
- Output registering:
  - out_code, out_none, out_last and out_valid are registered.
  - in_ready is a direct decode of the state register; no combinational path from in_valid or out_ready to any output.
- Latency: input handshake at edge t → first beat valid after edge t (visible in cycle t+1).
- Beat rate: with out_ready held 1, one beat per cycle.
- Recovery after a vector:
  - Last handshake at edge t → in_ready=1 in cycle t+1.
  - Next vector accepted at edge t+1 at earliest.
  - Sustained throughput: N beats per N+1 cycles.
- out_ready may be high while out_valid=0; it has no effect then.
- in_valid held with in_ready=0 is not an accept; the source must hold in_vec until the handshake.

## Test plan
- Reset and single beat:
  - Assert rst_n=0 mid-cycle → all outputs at reset values asynchronously, in_ready=1.
  - Release; send in_vec=8'b0000_0100 → one beat: out_code=2, out_last=1, out_none=0.
- Multi-bit, LSB_FIRST=1:
  - Send in_vec=8'b1010_0011 with out_ready=1 → codes 0,1,5,7 on consecutive cycles.
  - out_last=1 only on 7; in_ready returns the cycle after.
- Multi-bit, LSB_FIRST=0:
  - Same vector → codes 7,5,1,0, with out_last on 0.
  - Also send 8'hFF → codes 7..0, 8 beats.
- Zero vector:
  - Send in_vec=8'h00 → exactly one beat: out_code=0, out_none=1, out_last=1.
- Backpressure:
  - Send 8'b0001_0010; hold out_ready=0 for 5 cycles → out_code=1 stable, out_valid=1, in_ready=0.
  - Toggle in_vec meanwhile → no effect.
  - Release out_ready → codes 1 then 4.
- Reset mid-vector:
  - Send 8'hF0; after the first beat (code 4), pulse rst_n=0 → out_valid=0 immediately.
  - After release: in_ready=1, no further beats.
  - Next vector 8'h01 → single code 0.
